// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, immediate and
// result-source selectors, and the ALU-decode helper.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  // Only R-type honours funct7[5]; addi with instr[30]=1 is still an add.
  function automatic alu_ctrl_t alu_decode(input logic [2:0] funct3,
                                           input logic       is_rtype,
                                           input logic       funct7_b5);
    alu_ctrl_t op;
    case (funct3)
      3'b000:  op = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two combinational read ports with
// write-through from the single write port, x0 hardwired to zero.
module reg_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  // Reset wins over a writeback landing in the same cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (wr_en && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
  end

  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (wr_en && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate generation, register-file
// read, and the ID/EX pipeline register feeding execute.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            flush_e,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            reg_write_w,
  input  logic [AW-1:0]   rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [AW-1:0]   rs1_d,
  output logic [AW-1:0]   rs2_d,
  output logic            reg_write_e,
  output logic [1:0]      result_src_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic [2:0]      alu_control_e,
  output logic            alu_src_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [AW-1:0]   rs1_e,
  output logic [AW-1:0]   rs2_e,
  output logic [AW-1:0]   rd_e
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [AW-1:0]   rd_d;

  logic            reg_write_d;
  result_src_t     result_src_d;
  logic            mem_write_d;
  logic            jump_d;
  logic            branch_d;
  alu_ctrl_t       alu_control_d;
  logic            alu_src_d;
  imm_src_t        imm_src_d;
  logic            imm_valid_d;
  logic [XLEN-1:0] imm_ext_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;

  logic            reg_write_q;
  logic [1:0]      result_src_q;
  logic            mem_write_q;
  logic            jump_q;
  logic            branch_q;
  logic [2:0]      alu_control_q;
  logic            alu_src_q;
  logic [XLEN-1:0] rd1_q;
  logic [XLEN-1:0] rd2_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic [XLEN-1:0] imm_ext_q;
  logic [AW-1:0]   rs1_q;
  logic [AW-1:0]   rs2_q;
  logic [AW-1:0]   rd_q;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign rs1_d  = instr_d[19:15];
  assign rs2_d  = instr_d[24:20];
  assign rd_d   = instr_d[11:7];

  always_comb begin
    reg_write_d   = 1'b0;
    result_src_d  = RES_ALU;
    mem_write_d   = 1'b0;
    jump_d        = 1'b0;
    branch_d      = 1'b0;
    alu_control_d = ALU_ADD;
    alu_src_d     = 1'b0;
    imm_src_d     = IMM_I;
    imm_valid_d   = 1'b0;
    case (opcode)
      OP_LW: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = RES_MEM;
        imm_valid_d  = 1'b1;
      end
      OP_SW: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src_d   = IMM_S;
        imm_valid_d = 1'b1;
      end
      OP_R: begin
        reg_write_d   = 1'b1;
        alu_control_d = alu_decode(funct3, 1'b1, instr_d[30]);
      end
      OP_I: begin
        reg_write_d   = 1'b1;
        alu_src_d     = 1'b1;
        alu_control_d = alu_decode(funct3, 1'b0, instr_d[30]);
        imm_valid_d   = 1'b1;
      end
      OP_BEQ: begin
        branch_d      = 1'b1;
        alu_control_d = ALU_SUB;
        imm_src_d     = IMM_B;
        imm_valid_d   = 1'b1;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        result_src_d = RES_PC4;
        imm_src_d    = IMM_J;
        imm_valid_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // R-type and bubbles carry no immediate; drive zero so execute sees a clean value.
  always_comb begin
    imm_ext_d = '0;
    if (imm_valid_d) begin
      case (imm_src_d)
        IMM_I: imm_ext_d = {{20{instr_d[31]}}, instr_d[31:20]};
        IMM_S: imm_ext_d = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
        IMM_B: imm_ext_d = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25],
                            instr_d[11:8], 1'b0};
        IMM_J: imm_ext_d = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20],
                            instr_d[30:21], 1'b0};
        default: imm_ext_d = '0;
      endcase
    end
  end

  reg_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_reg_file (
    .clk      (clk),
    .srst     (srst),
    .we_i     (reg_write_w),
    .waddr_i  (rd_w),
    .wdata_i  (result_w),
    .raddr1_i (rs1_d),
    .raddr2_i (rs2_d),
    .rdata1_o (rd1_d),
    .rdata2_o (rd2_d)
  );

  always_ff @(posedge clk) begin
    if (srst || flush_e) begin
      reg_write_q   <= 1'b0;
      result_src_q  <= '0;
      mem_write_q   <= 1'b0;
      jump_q        <= 1'b0;
      branch_q      <= 1'b0;
      alu_control_q <= '0;
      alu_src_q     <= 1'b0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      pc_q          <= '0;
      pc_plus4_q    <= '0;
      imm_ext_q     <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
    end else begin
      reg_write_q   <= reg_write_d;
      result_src_q  <= result_src_d;
      mem_write_q   <= mem_write_d;
      jump_q        <= jump_d;
      branch_q      <= branch_d;
      alu_control_q <= alu_control_d;
      alu_src_q     <= alu_src_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      imm_ext_q     <= imm_ext_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
    end
  end

  assign reg_write_e   = reg_write_q;
  assign result_src_e  = result_src_q;
  assign mem_write_e   = mem_write_q;
  assign jump_e        = jump_q;
  assign branch_e      = branch_q;
  assign alu_control_e = alu_control_q;
  assign alu_src_e     = alu_src_q;
  assign rd1_e         = rd1_q;
  assign rd2_e         = rd2_q;
  assign pc_e          = pc_q;
  assign pc_plus4_e    = pc_plus4_q;
  assign imm_ext_e     = imm_ext_q;
  assign rs1_e         = rs1_q;
  assign rs2_e         = rs2_q;
  assign rd_e          = rd_q;

endmodule
